ccx_mem_arb: RTL and testbench



---
 rtl/ccx_pkg.sv | 9 +
 rtl/core_mem_bus.sv | 18 +
 rtl/ccx_mem_arb_sva.sv | 25 ++
 rtl/ccx_mem_arb.sv | 135 +++++++++++++
 tb/tb_ccx_mem_arb.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccx_pkg.sv
// Shared types for the core memory crossbar: owner encoding and request-type codes.
package ccx_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} ccx_owner_t;

    localparam logic RTYPE_INSTR = 1'b0;
    localparam logic RTYPE_DATA  = 1'b1;

endpackage

// File: rtl/core_mem_bus.sv
// Core-to-memory request/response bus. REQ is the requestor side, RSP the responder side.
interface core_mem_bus #(
    parameter int AW = 39,
    parameter int DW = 64
);
    logic              req;
    logic [AW-1:0]     addr;
    logic              wen;
    logic [DW/8-1:0]   strb;
    logic [DW-1:0]     wdata;
    logic              rtype;
    logic              gnt;
    logic              err;
    logic [DW-1:0]     rdata;

    modport REQ (output req, addr, wen, strb, wdata, rtype, input gnt, err, rdata);
    modport RSP (input req, addr, wen, strb, wdata, rtype, output gnt, err, rdata);
endinterface

// File: rtl/ccx_mem_arb_sva.sv
// Protocol checks on the forwarded request: a locked owner must keep req high and its fields stable.
module ccx_mem_arb_sva
    import ccx_pkg::*;
#(
    parameter int AW = 39,
    parameter int DW = 64
) (
    input logic            clk,
    input logic            reset,
    input ccx_owner_t      own,
    input logic            req,
    input logic            wen,
    input logic [AW-1:0]   addr,
    input logic [DW/8-1:0] strb,
    input logic [DW-1:0]   wdata
);

    // own != NONE means last cycle this same port was forwarded and not yet granted
    a_no_drop: assert property (@(posedge clk) disable iff (reset)
        (own != OWN_NONE) |-> req);

    a_stable: assert property (@(posedge clk) disable iff (reset)
        (own != OWN_NONE) |-> $stable({addr, wen, strb, wdata}));

endmodule

// File: rtl/ccx_mem_arb.sv
// Merges instruction-fetch and data requestors onto one memory bus: data priority,
// fetch anti-starvation counter, owner locked until the downstream grant.
module ccx_mem_arb
    import ccx_pkg::*;
#(
    parameter int AW         = 39,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input logic        g_clk,
    input logic        g_reset,
    core_mem_bus.RSP   imem,
    core_mem_bus.RSP   dmem,
    core_mem_bus.REQ   mem
);

    localparam int             CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  SMAX = CW'(STARVE_MAX);

    ccx_owner_t       own;
    ccx_owner_t       sel;
    logic [CW-1:0]    scnt;

    logic             fwd_req;
    logic             fwd_wen;
    logic             fwd_rtype;
    logic [AW-1:0]    fwd_addr;
    logic [DW/8-1:0]  fwd_strb;
    logic [DW-1:0]    fwd_wdata;

    // rtype from the upstream ports carries no meaning here; the arbiter sets its own
    logic unused_rtype;
    assign unused_rtype = imem.rtype ^ dmem.rtype;

    always_comb begin
        sel = OWN_NONE;
        if (g_reset) begin
            sel = OWN_NONE;
        end else if (own != OWN_NONE) begin
            sel = own;
        end else if (imem.req && dmem.req) begin
            sel = (scnt < SMAX) ? OWN_D : OWN_I;
        end else if (dmem.req) begin
            sel = OWN_D;
        end else if (imem.req) begin
            sel = OWN_I;
        end
    end

    always_comb begin
        fwd_req   = 1'b0;
        fwd_wen   = 1'b0;
        fwd_rtype = RTYPE_INSTR;
        fwd_addr  = '0;
        fwd_strb  = '0;
        fwd_wdata = '0;
        case (sel)
            OWN_I: begin
                fwd_req   = imem.req;
                fwd_wen   = imem.wen;
                fwd_rtype = RTYPE_INSTR;
                fwd_addr  = imem.addr;
                fwd_strb  = imem.strb;
                fwd_wdata = imem.wdata;
            end
            OWN_D: begin
                fwd_req   = dmem.req;
                fwd_wen   = dmem.wen;
                fwd_rtype = RTYPE_DATA;
                fwd_addr  = dmem.addr;
                fwd_strb  = dmem.strb;
                fwd_wdata = dmem.wdata;
            end
            default: ;
        endcase
    end

    assign mem.req   = fwd_req;
    assign mem.wen   = fwd_wen;
    assign mem.rtype = fwd_rtype;
    assign mem.addr  = fwd_addr;
    assign mem.strb  = fwd_strb;
    assign mem.wdata = fwd_wdata;

    always_comb begin
        imem.gnt   = 1'b0;
        imem.err   = 1'b0;
        imem.rdata = '0;
        dmem.gnt   = 1'b0;
        dmem.err   = 1'b0;
        dmem.rdata = '0;
        if (sel == OWN_I) begin
            imem.gnt   = mem.gnt;
            imem.err   = mem.err;
            imem.rdata = mem.rdata;
        end else if (sel == OWN_D) begin
            dmem.gnt   = mem.gnt;
            dmem.err   = mem.err;
            dmem.rdata = mem.rdata;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            own  <= OWN_NONE;
            scnt <= '0;
        end else begin
            if (mem.gnt) begin
                own <= OWN_NONE;
            end else if (fwd_req) begin
                own <= sel;
            end
            // only contended data wins count against fetch
            if (fwd_req && mem.gnt) begin
                if (sel == OWN_D && imem.req) begin
                    if (scnt < SMAX) scnt <= scnt + CW'(1);
                end else if (sel == OWN_I) begin
                    scnt <= '0;
                end
            end
        end
    end

    ccx_mem_arb_sva #(.AW(AW), .DW(DW)) u_sva (
        .clk   (g_clk),
        .reset (g_reset),
        .own   (own),
        .req   (fwd_req),
        .wen   (fwd_wen),
        .addr  (fwd_addr),
        .strb  (fwd_strb),
        .wdata (fwd_wdata)
    );

endmodule

// File: tb/tb_ccx_mem_arb.sv
// Bench for ccx_mem_arb: vector table, directed corner sequences, random traffic vs a reference model.
module tb_ccx_mem_arb;
    import ccx_pkg::*;

    localparam int AW = 39;
    localparam int DW = 64;
    localparam int SM = 4;

    logic g_clk   = 1'b0;
    logic g_reset = 1'b1;
    always #5 g_clk = ~g_clk;

    core_mem_bus #(.AW(AW), .DW(DW)) ibus ();
    core_mem_bus #(.AW(AW), .DW(DW)) dbus ();
    core_mem_bus #(.AW(AW), .DW(DW)) mbus ();

    ccx_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .imem    (ibus),
        .dmem    (dbus),
        .mem     (mbus)
    );

    int total = 0;
    int bad   = 0;

    // downstream slave: grants once the request has waited lat cycles (lat=0 is same-cycle)
    int          lat       = 0;
    int          pend      = 0;
    logic        err_flag  = 1'b0;
    logic [DW-1:0] slv_rdata = '0;

    always @(posedge g_clk) begin
        if (g_reset || !mbus.req || mbus.gnt) pend <= 0;
        else                                  pend <= pend + 1;
    end

    always_comb begin
        mbus.gnt   = mbus.req && (pend >= lat);
        mbus.err   = mbus.gnt && err_flag;
        mbus.rdata = mbus.gnt ? slv_rdata : '0;
    end

    typedef struct {
        logic          ir, dr;
        logic [AW-1:0] ia, da;
        logic          e_req, e_rt;
        logic [AW-1:0] e_addr;
        logic          e_ig, e_dg;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mkv(input int ir, input int dr, input int ia, input int da,
                                 input int er, input int ert, input int ea, input int eig, input int edg);
        vec_t v;
        v.ir = ir[0]; v.dr = dr[0]; v.ia = AW'(ia); v.da = AW'(da);
        v.e_req = er[0]; v.e_rt = ert[0]; v.e_addr = AW'(ea);
        v.e_ig = eig[0]; v.e_dg = edg[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge g_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_i(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        ibus.req = r; ibus.addr = a; ibus.wen = w; ibus.wdata = d;
        ibus.strb = w ? 8'hff : 8'h00;
    endtask

    task automatic set_d(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        dbus.req = r; dbus.addr = a; dbus.wen = w; dbus.wdata = d;
        dbus.strb = w ? 8'h0f : 8'h00;
    endtask

    // reference model state
    int busy   = 0;   // 0 none, 1 fetch, 2 data
    int streak = 0;
    int sel;
    logic e_req, e_g, i_done, d_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic e_wen;

    initial begin
        set_i(1'b1, 39'h55, 1'b0, 64'h0);
        set_d(1'b1, 39'h66, 1'b1, 64'h1234);
        ibus.rtype = 1'b1;
        dbus.rtype = 1'b0;
        lat = 0;

        // ---- reset state
        nxt();
        chk("rst_mreq", 64'(mbus.req), 64'd0);
        chk("rst_igt",  64'(ibus.gnt), 64'd0);
        chk("rst_dgt",  64'(dbus.gnt), 64'd0);
        chk("rst_addr", 64'(mbus.addr), 64'd0);
        nxt();
        chk("rst_own",  64'(dut.own), 64'(OWN_NONE));
        chk("rst_scnt", 64'(dut.scnt), 64'd0);
        g_reset = 1'b0;
        ibus.req = 1'b0;
        dbus.req = 1'b0;

        // ---- vector table, same-cycle slave; scnt walks 1,2,2,0,1..4,0 across rows
        tbl[0]  = mkv(1, 1, 'h100, 'h200, 1, 1, 'h200, 0, 1);
        tbl[1]  = mkv(1, 1, 'h104, 'h204, 1, 1, 'h204, 0, 1);
        tbl[2]  = mkv(0, 1, 'h000, 'h208, 1, 1, 'h208, 0, 1);
        tbl[3]  = mkv(1, 0, 'h10c, 'h000, 1, 0, 'h10c, 1, 0);
        tbl[4]  = mkv(1, 1, 'h110, 'h210, 1, 1, 'h210, 0, 1);
        tbl[5]  = mkv(1, 1, 'h114, 'h214, 1, 1, 'h214, 0, 1);
        tbl[6]  = mkv(1, 1, 'h118, 'h218, 1, 1, 'h218, 0, 1);
        tbl[7]  = mkv(1, 1, 'h11c, 'h21c, 1, 1, 'h21c, 0, 1);
        tbl[8]  = mkv(1, 1, 'h120, 'h220, 1, 0, 'h120, 1, 0);
        tbl[9]  = mkv(0, 0, 'h124, 'h224, 0, 0, 'h000, 0, 0);
        tbl[10] = mkv(1, 1, 'h128, 'h228, 1, 1, 'h228, 0, 1);
        for (int k = 0; k < 11; k++) begin
            nxt();
            set_i(tbl[k].ir, tbl[k].ia, 1'b0, 64'h0);
            set_d(tbl[k].dr, tbl[k].da, 1'b1, 64'(k));
            slv_rdata = 64'hA5A5_0000 + 64'(k);
            lat = 0;
            settle();
            chk("tbl_mreq",   64'(mbus.req),   64'(tbl[k].e_req));
            chk("tbl_rtype",  64'(mbus.rtype), 64'(tbl[k].e_rt));
            chk("tbl_addr",   64'(mbus.addr),  64'(tbl[k].e_addr));
            chk("tbl_igt",    64'(ibus.gnt),   64'(tbl[k].e_ig));
            chk("tbl_dgt",    64'(dbus.gnt),   64'(tbl[k].e_dg));
            chk("tbl_irdata", ibus.rdata, tbl[k].e_ig ? slv_rdata : 64'h0);
            chk("tbl_drdata", dbus.rdata, tbl[k].e_dg ? slv_rdata : 64'h0);
        end
        nxt();
        ibus.req = 1'b0; dbus.req = 1'b0;
        nxt();
        chk("tbl_scnt_end", 64'(dut.scnt), 64'd1);

        // ---- fetch-only, 3-cycle wait; a data request arriving meanwhile must wait
        g_reset = 1'b1; nxt(); g_reset = 1'b0;
        nxt();
        set_i(1'b1, 39'h100, 1'b0, 64'h0);
        lat = 3; slv_rdata = 64'hDEAD;
        settle();
        chk("i3_mreq",  64'(mbus.req),   64'd1);
        chk("i3_rtype", 64'(mbus.rtype), 64'd0);
        chk("i3_addr",  64'(mbus.addr),  64'h100);
        nxt();
        set_d(1'b1, 39'h40, 1'b1, 64'hBEEF);
        settle();
        chk("i3_own1",  64'(dut.own),    64'(OWN_I));
        chk("i3_lock",  64'(mbus.addr),  64'h100);
        chk("i3_dgt1",  64'(dbus.gnt),   64'd0);
        nxt(); settle();
        chk("i3_own2",  64'(dut.own),    64'(OWN_I));
        nxt(); settle();
        chk("i3_igt",   64'(ibus.gnt),   64'd1);
        chk("i3_rdata", ibus.rdata,      64'hDEAD);
        chk("i3_dgt3",  64'(dbus.gnt),   64'd0);
        chk("i3_drd3",  dbus.rdata,      64'h0);
        nxt();
        ibus.req = 1'b0; lat = 0;
        settle();
        chk("i3_own4",  64'(dut.own),    64'(OWN_NONE));
        chk("i3_next_d", 64'(mbus.rtype), 64'd1);
        chk("i3_dgt4",  64'(dbus.gnt),   64'd1);
        nxt();
        dbus.req = 1'b0;

        // ---- both request with scnt=0: data first, fetch held off until data completes
        nxt();
        set_i(1'b1, 39'h500, 1'b0, 64'h0);
        set_d(1'b1, 39'h600, 1'b0, 64'h0);
        lat = 1;
        settle();
        chk("both_rtype", 64'(mbus.rtype), 64'd1);
        chk("both_igt0",  64'(ibus.gnt),   64'd0);
        nxt(); settle();
        chk("both_dgt",   64'(dbus.gnt),   64'd1);
        chk("both_igt1",  64'(ibus.gnt),   64'd0);
        nxt();
        dbus.req = 1'b0;
        settle();
        chk("both_i_sel", 64'(mbus.rtype), 64'd0);
        chk("both_addr",  64'(mbus.addr),  64'h500);
        chk("both_scnt",  64'(dut.scnt),   64'd1);
        nxt(); settle();
        chk("both_igt",   64'(ibus.gnt),   64'd1);
        nxt();
        ibus.req = 1'b0;
        settle();
        chk("both_scnt0", 64'(dut.scnt),   64'd0);

        // ---- error response on a data store with fetch pending
        nxt();
        set_i(1'b1, 39'h200, 1'b0, 64'h0);
        set_d(1'b1, 39'h8, 1'b1, 64'hCAFE);
        lat = 0; err_flag = 1'b1;
        settle();
        chk("err_dgt",  64'(dbus.gnt), 64'd1);
        chk("err_derr", 64'(dbus.err), 64'd1);
        chk("err_ierr", 64'(ibus.err), 64'd0);
        nxt();
        dbus.req = 1'b0; err_flag = 1'b0; lat = 5;
        settle();
        chk("err_derr1", 64'(dbus.err), 64'd0);
        chk("err_scnt",  64'(dut.scnt), 64'd1);
        chk("err_own",   64'(dut.own),  64'(OWN_NONE));
        nxt();
        lat = 0;
        nxt();
        ibus.req = 1'b0;

        // ---- same-cycle grant: own never leaves NONE, data taken the next cycle
        nxt();
        set_i(1'b1, 39'h300, 1'b0, 64'h0);
        lat = 0;
        settle();
        chk("sc_igt", 64'(ibus.gnt), 64'd1);
        nxt();
        ibus.req = 1'b0;
        set_d(1'b1, 39'h310, 1'b0, 64'h0);
        settle();
        chk("sc_own",   64'(dut.own),    64'(OWN_NONE));
        chk("sc_rtype", 64'(mbus.rtype), 64'd1);
        chk("sc_dgt",   64'(dbus.gnt),   64'd1);
        nxt();
        dbus.req = 1'b0;

        // ---- reset in the middle of an outstanding data transaction
        nxt();
        set_i(1'b1, 39'h400, 1'b0, 64'h0);
        set_d(1'b1, 39'h3f0, 1'b0, 64'h0);
        lat = 0;
        nxt();
        set_d(1'b1, 39'h3f8, 1'b0, 64'h0);
        lat = 20;
        nxt(); settle();
        chk("rm_own", 64'(dut.own), 64'(OWN_D));
        nxt();
        g_reset = 1'b1;
        settle();
        chk("rm_mreq", 64'(mbus.req), 64'd0);
        chk("rm_igt",  64'(ibus.gnt), 64'd0);
        chk("rm_dgt",  64'(dbus.gnt), 64'd0);
        nxt();
        g_reset = 1'b0;
        dbus.req = 1'b0;
        settle();
        chk("rm_own_n", 64'(dut.own),    64'(OWN_NONE));
        chk("rm_scnt",  64'(dut.scnt),   64'd0);
        chk("rm_mreq1", 64'(mbus.req),   64'd1);
        chk("rm_rtype", 64'(mbus.rtype), 64'd0);
        chk("rm_addr",  64'(mbus.addr),  64'h400);
        lat = 0;
        nxt();
        ibus.req = 1'b0;

        // ---- random traffic against the reference model
        nxt(); g_reset = 1'b1;
        nxt(); g_reset = 1'b0;
        busy = 0; streak = 0; i_done = 1'b0; d_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            if (i_done) ibus.req = 1'b0;
            if (d_done) dbus.req = 1'b0;
            if (!ibus.req && $urandom_range(0, 2) == 0)
                set_i(1'b1, AW'({$urandom, $urandom}), 1'($urandom), {$urandom, $urandom});
            if (!dbus.req && $urandom_range(0, 1) == 0)
                set_d(1'b1, AW'({$urandom, $urandom}), 1'($urandom), {$urandom, $urandom});
            ibus.rtype = 1'($urandom);
            dbus.rtype = 1'($urandom);
            lat = $urandom_range(0, 3);
            err_flag = ($urandom_range(0, 3) == 0);
            slv_rdata = {$urandom, $urandom};
            settle();

            if (busy != 0)                 sel = busy;
            else if (ibus.req && dbus.req) sel = (streak < SM) ? 2 : 1;
            else if (dbus.req)             sel = 2;
            else if (ibus.req)             sel = 1;
            else                           sel = 0;
            e_req  = (sel == 1) ? ibus.req   : (sel == 2) ? dbus.req   : 1'b0;
            e_addr = (sel == 1) ? ibus.addr  : (sel == 2) ? dbus.addr  : '0;
            e_wd   = (sel == 1) ? ibus.wdata : (sel == 2) ? dbus.wdata : '0;
            e_wen  = (sel == 1) ? ibus.wen   : (sel == 2) ? dbus.wen   : 1'b0;
            e_g    = e_req && (pend >= lat);

            chk("rnd_mreq",   64'(mbus.req),   64'(e_req));
            chk("rnd_rtype",  64'(mbus.rtype), 64'(sel == 2));
            chk("rnd_addr",   64'(mbus.addr),  64'(e_addr));
            chk("rnd_wdata",  mbus.wdata,      e_wd);
            chk("rnd_wen",    64'(mbus.wen),   64'(e_wen));
            chk("rnd_igt",    64'(ibus.gnt),   64'(sel == 1 && e_g));
            chk("rnd_dgt",    64'(dbus.gnt),   64'(sel == 2 && e_g));
            chk("rnd_irdata", ibus.rdata,      (sel == 1 && e_g) ? slv_rdata : 64'h0);
            chk("rnd_derr",   64'(dbus.err),   64'(sel == 2 && e_g && err_flag));

            i_done = (sel == 1) && e_g;
            d_done = (sel == 2) && e_g;
            if (e_g) begin
                if (sel == 2 && ibus.req) streak = (streak < SM) ? streak + 1 : SM;
                else if (sel == 1)        streak = 0;
                busy = 0;
            end else if (e_req) begin
                busy = sel;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
